// File: rtl/instr_reader.sv
// instr_reader: read-side engine for the instruction register.
// Walks a window of slots starting at base_ptr, fetches each 68-bit
// instruction word, executes its opcode on the two signed 32-bit operands
// and presents one 64-bit result per slot on a valid/ready stream.
//
// Build option: define INSTR_READER_DIV_EN to build the DIV/MOD datapath.
// Without it, opcodes 6 and 7 are reported as illegal (result 0, err 1).
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; pointer/remaining loaded on start
// FETCH  | read_pointer stable, instruction_word captured at cycle end
// EXEC   | opcode evaluated, result/result_ptr/result_err registered
// OUT    | result_valid high, payload held until result_ready
// DONE   | one-cycle done pulse, then back to IDLE
module instr_reader #(
  parameter int DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [$clog2(DEPTH)-1:0]   base_ptr,
  input  logic [5:0]                 count,
  output logic [$clog2(DEPTH)-1:0]   read_pointer,
  input  logic [67:0]                instruction_word,
  output logic                       result_valid,
  input  logic                       result_ready,
  output logic [63:0]                result,
  output logic [$clog2(DEPTH)-1:0]   result_ptr,
  output logic                       result_err,
  output logic                       busy,
  output logic                       done
);

  localparam int PW = $clog2(DEPTH);

  localparam logic [3:0] OP_ZERO  = 4'd0;
  localparam logic [3:0] OP_PASSA = 4'd1;
  localparam logic [3:0] OP_PASSB = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_MULT  = 4'd5;
`ifdef INSTR_READER_DIV_EN
  localparam logic [3:0] OP_DIV   = 4'd6;
  localparam logic [3:0] OP_MOD   = 4'd7;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_OUT   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state;
  logic [PW-1:0]       ptr;
  logic [PW-1:0]       ptr_next;
  logic [5:0]          remaining;
  logic [67:0]         instr_q;

  logic [3:0]          opc;
  logic signed [63:0]  a_ext;
  logic signed [63:0]  b_ext;
  logic signed [63:0]  exec_res;
  logic                exec_err;

  assign read_pointer = ptr;
  assign busy         = (state != S_IDLE);

  // Pointer advance wraps at the last slot so any DEPTH works, not just powers of two.
  always_comb begin
    ptr_next = ptr + 1'b1;
    if (ptr == PW'(DEPTH - 1)) begin
      ptr_next = '0;
    end
  end

  // Opcode evaluation on the captured word; operands sign-extended so ADD/SUB/MULT are exact.
  always_comb begin
    opc      = instr_q[67:64];
    a_ext    = {{32{instr_q[63]}}, instr_q[63:32]};
    b_ext    = {{32{instr_q[31]}}, instr_q[31:0]};
    exec_res = '0;
    exec_err = 1'b0;
    case (opc)
      OP_ZERO:  exec_res = '0;
      OP_PASSA: exec_res = a_ext;
      OP_PASSB: exec_res = b_ext;
      OP_ADD:   exec_res = a_ext + b_ext;
      OP_SUB:   exec_res = a_ext - b_ext;
      OP_MULT:  exec_res = a_ext * b_ext;
`ifdef INSTR_READER_DIV_EN
      OP_DIV: begin
        if (b_ext == 64'sd0) begin
          exec_err = 1'b1;
        end else begin
          exec_res = a_ext / b_ext;
        end
      end
      OP_MOD: begin
        if (b_ext == 64'sd0) begin
          exec_err = 1'b1;
        end else begin
          exec_res = a_ext % b_ext;
        end
      end
`endif
      default: begin
        exec_res = '0;
        exec_err = 1'b1;
      end
    endcase
  end

  // Sequencer: fetch / execute / present one beat per slot, with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      ptr          <= '0;
      remaining    <= '0;
      instr_q      <= '0;
      result       <= '0;
      result_ptr   <= '0;
      result_err   <= 1'b0;
      result_valid <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            ptr       <= base_ptr;
            remaining <= count;
            if (count == 6'd0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          instr_q <= instruction_word;
          state   <= S_EXEC;
        end
        S_EXEC: begin
          result       <= exec_res;
          result_err   <= exec_err;
          result_ptr   <= ptr;
          result_valid <= 1'b1;
          state        <= S_OUT;
        end
        S_OUT: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            ptr          <= ptr_next;
            remaining    <= remaining - 6'd1;
            if (remaining == 6'd1) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_reader.sv
// Directed bench for instr_reader with a behavioural 32-slot instruction register.
module tb_instr_reader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  base_ptr;
  logic [5:0]  count;
  logic [4:0]  read_pointer;
  logic [67:0] instruction_word;
  logic        result_valid;
  logic        result_ready;
  logic [63:0] result;
  logic [4:0]  result_ptr;
  logic        result_err;
  logic        busy;
  logic        done;

  logic [67:0] mem [32];

  int checks = 0;
  int errors = 0;

  instr_reader #(.DEPTH(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .base_ptr         (base_ptr),
    .count            (count),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .result_valid     (result_valid),
    .result_ready     (result_ready),
    .result           (result),
    .result_ptr       (result_ptr),
    .result_err       (result_err),
    .busy             (busy),
    .done             (done)
  );

  assign instruction_word = mem[read_pointer];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Steps until result_valid (bounded), reporting how many cycles it took.
  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (!result_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_valid_seen"}, 64'(result_valid), 64'd1);
  endtask

  function automatic logic [67:0] mk(input logic [3:0] o, input int a, input int b);
    logic [31:0] ua;
    logic [31:0] ub;
    ua = a;
    ub = b;
    return {o, ua, ub};
  endfunction

  initial begin
    int          n;
    logic [63:0] exp_res [8];
    logic        exp_err [8];
    logic [63:0] held_res;
    logic [4:0]  held_ptr;
    logic [4:0]  wrap_ptr [4];
    logic [63:0] wrap_res [4];

    reset        = 1'b1;
    start        = 1'b0;
    base_ptr     = '0;
    count        = '0;
    result_ready = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = '0;

    // Reset state
    step();
    step();
    chk("rst_read_pointer", 64'(read_pointer), 64'd0);
    chk("rst_result_valid", 64'(result_valid), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_result_ptr", 64'(result_ptr), 64'd0);
    chk("rst_result_err", 64'(result_err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    reset = 1'b0;
    step();

    // count = 0: done one cycle after start, no beats
    base_ptr = 5'd3;
    count    = 6'd0;
    start    = 1'b1;
    step();
    start = 1'b0;
    chk("cnt0_done", 64'(done), 64'd1);
    chk("cnt0_busy", 64'(busy), 64'd1);
    chk("cnt0_valid", 64'(result_valid), 64'd0);
    step();
    chk("cnt0_done_drop", 64'(done), 64'd0);
    chk("cnt0_busy_drop", 64'(busy), 64'd0);
    chk("cnt0_valid_after", 64'(result_valid), 64'd0);

    // Single ADD, exact cycle timing
    mem[4]       = mk(4'd3, -5, 12);
    base_ptr     = 5'd4;
    count        = 6'd1;
    result_ready = 1'b1;
    start        = 1'b1;
    step();
    start = 1'b0;
    chk("add_fetch_busy", 64'(busy), 64'd1);
    chk("add_fetch_rptr", 64'(read_pointer), 64'd4);
    step();
    chk("add_exec_valid", 64'(result_valid), 64'd0);
    step();
    chk("add_valid_n3", 64'(result_valid), 64'd1);
    chk("add_result", result, 64'd7);
    chk("add_ptr", 64'(result_ptr), 64'd4);
    chk("add_err", 64'(result_err), 64'd0);
    step();
    chk("add_done_n4", 64'(done), 64'd1);
    chk("add_done_busy", 64'(busy), 64'd1);
    chk("add_done_valid", 64'(result_valid), 64'd0);
    step();
    chk("add_idle_busy", 64'(busy), 64'd0);
    chk("add_idle_done", 64'(done), 64'd0);

    // All opcodes, a = -7, b = 2
    for (int i = 0; i < 8; i++) mem[i] = mk(4'(i), -7, 2);
    exp_res[0] = 64'sd0;
    exp_res[1] = -64'sd7;
    exp_res[2] = 64'sd2;
    exp_res[3] = -64'sd5;
    exp_res[4] = -64'sd9;
    exp_res[5] = -64'sd14;
    for (int i = 0; i < 6; i++) exp_err[i] = 1'b0;
`ifdef INSTR_READER_DIV_EN
    exp_res[6] = -64'sd3;
    exp_res[7] = -64'sd1;
    exp_err[6] = 1'b0;
    exp_err[7] = 1'b0;
`else
    exp_res[6] = 64'd0;
    exp_res[7] = 64'd0;
    exp_err[6] = 1'b1;
    exp_err[7] = 1'b1;
`endif
    base_ptr = 5'd0;
    count    = 6'd8;
    start    = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_valid($sformatf("ops%0d", i), n);
      chk($sformatf("ops%0d_latency", i), 64'(n), 64'd2);
      chk($sformatf("ops%0d_result", i), result, exp_res[i]);
      chk($sformatf("ops%0d_ptr", i), 64'(result_ptr), 64'(i));
      chk($sformatf("ops%0d_err", i), 64'(result_err), 64'(exp_err[i]));
      step();
    end
    chk("ops_done", 64'(done), 64'd1);
    step();
    chk("ops_idle", 64'(busy), 64'd0);

    // Error cases and 32x32 signed multiply extreme
    mem[8]  = mk(4'd6, 9, 0);
    mem[9]  = mk(4'd12, 3, 4);
    mem[10] = mk(4'd5, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    base_ptr = 5'd8;
    count    = 6'd3;
    start    = 1'b1;
    step();
    start = 1'b0;
    wait_valid("div0", n);
    chk("div0_result", result, 64'd0);
    chk("div0_err", 64'(result_err), 64'd1);
    step();
    wait_valid("illegal", n);
    chk("illegal_result", result, 64'd0);
    chk("illegal_err", 64'(result_err), 64'd1);
    step();
    wait_valid("mult_max", n);
    chk("mult_max_result", result, 64'h3FFF_FFFF_0000_0001);
    chk("mult_max_err", 64'(result_err), 64'd0);
    step();
    chk("err_done", 64'(done), 64'd1);
    step();

    // Wrap-around with 5-cycle backpressure on every beat; stray start ignored
    mem[30] = mk(4'd3, 1, 1);
    mem[31] = mk(4'd4, 10, 3);
    mem[0]  = mk(4'd2, 0, 100);
    mem[1]  = mk(4'd5, -3, 4);
    wrap_ptr[0] = 5'd30; wrap_res[0] = 64'd2;
    wrap_ptr[1] = 5'd31; wrap_res[1] = 64'd7;
    wrap_ptr[2] = 5'd0;  wrap_res[2] = 64'd100;
    wrap_ptr[3] = 5'd1;  wrap_res[3] = -64'sd12;
    result_ready = 1'b0;
    base_ptr     = 5'd30;
    count        = 6'd4;
    start        = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_valid($sformatf("wrap%0d", k), n);
      chk($sformatf("wrap%0d_ptr", k), 64'(result_ptr), 64'(wrap_ptr[k]));
      chk($sformatf("wrap%0d_result", k), result, wrap_res[k]);
      held_res = result;
      held_ptr = result_ptr;
      for (int s = 0; s < 5; s++) begin
        if (k == 0 && s == 1) begin
          base_ptr = 5'd4;
          count    = 6'd1;
          start    = 1'b1;
        end
        step();
        start = 1'b0;
        chk($sformatf("wrap%0d_stall%0d_valid", k, s), 64'(result_valid), 64'd1);
        chk($sformatf("wrap%0d_stall%0d_result", k, s), result, held_res);
        chk($sformatf("wrap%0d_stall%0d_ptr", k, s), 64'(result_ptr), 64'(held_ptr));
        chk($sformatf("wrap%0d_stall%0d_done", k, s), 64'(done), 64'd0);
      end
      result_ready = 1'b1;
      step();
      result_ready = 1'b0;
      chk($sformatf("wrap%0d_post_valid", k), 64'(result_valid), 64'd0);
      chk($sformatf("wrap%0d_post_done", k), 64'(done), 64'(k == 3));
    end
    step();
    chk("wrap_idle_busy", 64'(busy), 64'd0);
    chk("wrap_idle_done", 64'(done), 64'd0);

    // Reset during third beat's OUT
    for (int i = 0; i < 8; i++) mem[i] = mk(4'd1, 100 + i, 0);
    result_ready = 1'b1;
    base_ptr     = 5'd0;
    count        = 6'd8;
    start        = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wait_valid($sformatf("mid%0d", k), n);
      chk($sformatf("mid%0d_result", k), result, 64'(100 + k));
      step();
    end
    result_ready = 1'b0;
    wait_valid("mid2", n);
    chk("mid2_ptr", 64'(result_ptr), 64'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_valid", 64'(result_valid), 64'd0);
    chk("mid_rst_result", result, 64'd0);
    chk("mid_rst_ptr", 64'(result_ptr), 64'd0);
    chk("mid_rst_err", 64'(result_err), 64'd0);
    chk("mid_rst_rptr", 64'(read_pointer), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    result_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      step();
      chk($sformatf("mid_quiet%0d_done", s), 64'(done), 64'd0);
      chk($sformatf("mid_quiet%0d_busy", s), 64'(busy), 64'd0);
    end

    // Fresh start after abort
    mem[4]   = mk(4'd3, -5, 12);
    base_ptr = 5'd4;
    count    = 6'd1;
    start    = 1'b1;
    step();
    start = 1'b0;
    wait_valid("fresh", n);
    chk("fresh_latency", 64'(n), 64'd2);
    chk("fresh_result", result, 64'd7);
    chk("fresh_ptr", 64'(result_ptr), 64'd4);
    step();
    chk("fresh_done", 64'(done), 64'd1);
    step();
    chk("fresh_idle", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
